// File: rtl/csa3_pipe_accumulator.sv
// csa3_pipe_accumulator: two-stage three-operand adder with optional running
// accumulator. Stage 1 reduces the operands to a sum/carry pair with a
// carry-save layer; stage 2 resolves them with a carry-propagate add and,
// when requested, folds the result into the accumulator.
// Build option: define CSA3_SAT_EN to make accumulator overflow saturate at
// all-ones instead of wrapping modulo 2^OUT_WIDTH.

module csa3_pipe_accumulator #(
  parameter int WIDTH     = 12,
  parameter int OUT_WIDTH = WIDTH + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] sum,
  output logic                 ovf
);

  logic                 s1Valid_q, s1Valid_d;
  logic [WIDTH-1:0]     s1Sum_q, s1Sum_d;
  logic [WIDTH-1:0]     s1Carry_q, s1Carry_d;
  logic                 s1AccEn_q, s1AccEn_d;
  logic                 s1AccClr_q, s1AccClr_d;

  logic                 outValid_q, outValid_d;
  logic [OUT_WIDTH-1:0] sum_q, sum_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  logic                 inXfer;
  logic                 s2Load;
  logic [OUT_WIDTH-1:0] cpaResult;
  logic [OUT_WIDTH:0]   accTotal;
  logic [OUT_WIDTH-1:0] accOnAdd;

  // Stage 2 takes a new entry whenever stage 1 holds one and the output
  // register is empty or being drained this cycle; stage 1 can then refill
  // in the same cycle, giving full throughput with a two-entry capacity.
  assign s2Load   = s1Valid_q && (!outValid_q || out_ready);
  assign in_ready = rst_n && (!s1Valid_q || s2Load);
  assign inXfer   = in_valid && in_ready;

  assign out_valid = outValid_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;

  // Carry-save layer: bitwise sum and majority carry of the three operands.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Sum_d    = s1Sum_q;
    s1Carry_d  = s1Carry_q;
    s1AccEn_d  = s1AccEn_q;
    s1AccClr_d = s1AccClr_q;
    if (inXfer) begin
      s1Valid_d  = 1'b1;
      s1Sum_d    = a ^ b ^ c;
      s1Carry_d  = (a & b) | (a & c) | (b & c);
      s1AccEn_d  = acc_en;
      s1AccClr_d = acc_clr;
    end else if (s2Load) begin
      s1Valid_d = 1'b0;
    end
  end

  // Carry-propagate add plus the one-bit-wider accumulate sum used to detect overflow.
  always_comb begin
    cpaResult = OUT_WIDTH'(s1Sum_q) + (OUT_WIDTH'(s1Carry_q) << 1);
    accTotal  = {1'b0, acc_q} + {1'b0, cpaResult};
`ifdef CSA3_SAT_EN
    accOnAdd  = accTotal[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : accTotal[OUT_WIDTH-1:0];
`else
    accOnAdd  = accTotal[OUT_WIDTH-1:0];
`endif
  end

  // Output register and accumulator update; both change only on a stage-2 load.
  always_comb begin
    outValid_d = outValid_q;
    sum_d      = sum_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    if (s2Load) begin
      outValid_d = 1'b1;
      case ({s1AccEn_q, s1AccClr_q})
        2'b00: begin
          sum_d = cpaResult;
        end
        2'b01: begin
          sum_d = cpaResult;
          acc_d = '0;
          ovf_d = 1'b0;
        end
        2'b10: begin
          acc_d = accOnAdd;
          sum_d = accOnAdd;
          if (accTotal[OUT_WIDTH]) begin
            ovf_d = 1'b1;
          end
        end
        default: begin
          acc_d = cpaResult;
          sum_d = cpaResult;
          ovf_d = 1'b0;
        end
      endcase
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // Control and result state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      outValid_q <= 1'b0;
      sum_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      outValid_q <= outValid_d;
      sum_q      <= sum_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

  // Stage-1 payload only matters while s1Valid_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    s1Sum_q    <= s1Sum_d;
    s1Carry_q  <= s1Carry_d;
    s1AccEn_q  <= s1AccEn_d;
    s1AccClr_q <= s1AccClr_d;
  end

endmodule

// File: tb/tb_csa3_pipe_accumulator.sv
// Testbench for csa3_pipe_accumulator (WIDTH=12, OUT_WIDTH=14).
// A transaction-level model predicts each result in order; a monitor compares
// the DUT against it every cycle, and directed sequences pin literal values.
// Honors CSA3_SAT_EN for the expected overflow behaviour.

module tb_csa3_pipe_accumulator;

  localparam int W  = 12;
  localparam int OW = 14;
  localparam longint MOD = 64'd1 << OW;
`ifdef CSA3_SAT_EN
  localparam int OVF_SUM = 16383;
`else
  localparam int OVF_SUM = 8186;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b, c;
  logic          acc_en;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] sum;
  logic          ovf;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    longint sumVal;
    bit     ovfVal;
    int     readyCycle;
  } exp_t;

  exp_t   expQ[$];
  longint mAcc = 0;
  bit     mOvf = 0;

  csa3_pipe_accumulator #(.WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index used to time when each result must become visible.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timeout waiting for DUT (t=%0t)", name, $time);
  endtask

  // Monitor: ready/valid and results checked every cycle against the model.
  always @(negedge clk) begin : monitor
    longint r;
    longint t;
    exp_t   e;
    bit     expValid;
    bit     expReady;
    if (!rst_n) begin
      checkOutput("mon_in_ready_reset", in_ready, 0);
      expQ.delete();
      mAcc = 0;
      mOvf = 0;
    end else begin
      expReady = (expQ.size() < 2) || out_ready;
      checkOutput("mon_in_ready", in_ready, expReady);
      expValid = (expQ.size() > 0) && (cycle >= expQ[0].readyCycle);
      checkOutput("mon_out_valid", out_valid, expValid);
      if (expValid && out_valid) begin
        checkOutput("mon_sum", sum, expQ[0].sumVal);
        checkOutput("mon_ovf", ovf, expQ[0].ovfVal);
        if (out_ready) void'(expQ.pop_front());
      end
      if (in_valid && in_ready) begin
        r = longint'(a) + longint'(b) + longint'(c);
        if (acc_en && acc_clr) begin
          mAcc = r;
          mOvf = 0;
          e.sumVal = r;
        end else if (acc_en) begin
          t = mAcc + r;
          if (t >= MOD) begin
            mOvf = 1;
`ifdef CSA3_SAT_EN
            mAcc = MOD - 1;
`else
            mAcc = t - MOD;
`endif
          end else begin
            mAcc = t;
          end
          e.sumVal = mAcc;
        end else if (acc_clr) begin
          mAcc = 0;
          mOvf = 0;
          e.sumVal = r;
        end else begin
          e.sumVal = r;
        end
        e.ovfVal = mOvf;
        e.readyCycle = cycle + 2;
        expQ.push_back(e);
      end
    end
  end

  // One transaction on an idle pipeline; checks latency and literal result.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                               input logic [W-1:0] tc, input logic en, input logic clr,
                               input longint expSum, input bit expOvf, input string name);
    int  waitCnt;
    bit  seen;
    @(posedge clk); #1;
    a = ta; b = tb2; c = tc; acc_en = en; acc_clr = clr;
    in_valid = 1'b1; out_ready = 1'b1;
    waitCnt = 0;
    @(negedge clk);
    while (!in_ready && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      reportTimeout({name, "_accept"});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = 0;
      for (int n = 1; n <= 10 && !seen; n++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1;
          checkOutput({name, "_latency"}, n, 2);
          checkOutput({name, "_sum"}, sum, expSum);
          checkOutput({name, "_ovf"}, ovf, expOvf);
        end
      end
      if (!seen) reportTimeout({name, "_result"});
    end
  endtask

  // Stalls the output, fills the pipe, then drains it one result per cycle.
  task automatic backpressureTest();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; acc_en = 1'b0; acc_clr = 1'b0;
    a = 1; b = 1; c = 1;
    @(negedge clk); checkOutput("bp_ready_first", in_ready, 1);
    @(posedge clk); #1; a = 2; b = 2; c = 2;
    @(negedge clk); checkOutput("bp_ready_second", in_ready, 1);
    @(posedge clk); #1; a = 3; b = 3; c = 3;
    @(negedge clk); checkOutput("bp_stall", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bp_stall_hold", in_ready, 0);
    checkOutput("bp_held_valid", out_valid, 1);
    checkOutput("bp_held_sum", sum, 3);
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_ready_release", in_ready, 1);
    checkOutput("bp_out1", sum, 3);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_valid2", out_valid, 1);
    checkOutput("bp_out2", sum, 6);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bp_valid3", out_valid, 1);
    checkOutput("bp_out3", sum, 9);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bp_drained", out_valid, 0);
  endtask

  // Two accumulates left in flight are dropped by a one-cycle reset pulse.
  task automatic resetMidFlightTest();
    applyStimulus(12'd4095, 12'd4095, 12'd4095, 1'b1, 1'b1, 12285, 1'b0, "rmf_pre1");
    applyStimulus(12'd4095, 12'd4095, 12'd4095, 1'b1, 1'b0, OVF_SUM, 1'b1, "rmf_pre2");
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; acc_en = 1'b1; acc_clr = 1'b0;
    a = 7; b = 7; c = 7;
    @(posedge clk); #1;
    a = 9; b = 9; c = 9;
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rmf_out_valid", out_valid, 0);
    checkOutput("rmf_sum", sum, 0);
    checkOutput("rmf_ovf", ovf, 0);
    checkOutput("rmf_in_ready", in_ready, 1);
    applyStimulus(12'd1, 12'd1, 12'd1, 1'b1, 1'b0, 3, 1'b0, "rmf_post_acc");
  endtask

  // Random traffic with random backpressure, modes and rare resets.
  task automatic randomTest(input int nCycles);
    for (int i = 0; i < nCycles; i++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom_range(0, 299) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = ($urandom_range(0, 3) == 0) ? 12'hFFF : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 12'hFFF : W'($urandom);
      c = ($urandom_range(0, 3) == 0) ? 12'hFFF : W'($urandom);
      acc_en  = ($urandom_range(0, 2) != 0);
      acc_clr = ($urandom_range(0, 9) == 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  // Main sequence.
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; acc_en = 1'b0; acc_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_in_ready", in_ready, 1);

    applyStimulus(12'd4095, 12'd4095, 12'd4095, 1'b0, 1'b0, 12285, 1'b0, "plain_max");
    applyStimulus(12'd1, 12'd2, 12'd3, 1'b1, 1'b1, 6, 1'b0, "acc_first");
    applyStimulus(12'd10, 12'd20, 12'd30, 1'b1, 1'b0, 66, 1'b0, "acc_second");
    applyStimulus(12'd4095, 12'd4095, 12'd4095, 1'b1, 1'b1, 12285, 1'b0, "ovf_first");
    applyStimulus(12'd4095, 12'd4095, 12'd4095, 1'b1, 1'b0, OVF_SUM, 1'b1, "ovf_second");
    applyStimulus(12'd0, 12'd0, 12'd4095, 1'b0, 1'b0, 4095, 1'b1, "ovf_sticky_plain");
    applyStimulus(12'd0, 12'd0, 12'd1, 1'b0, 1'b1, 1, 1'b0, "ovf_clear");

    backpressureTest();
    resetMidFlightTest();
    randomTest(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/csa3_pipe_accumulator.md
Name: csa3_pipe_accumulator

Overview:
- Parametrised, pipelined successor to the team's fixed 12-bit three-operand adder.
- Each accepted transaction sums three WIDTH-bit operands through a carry-save stage, then a carry-propagate stage.
- The result is returned at full width with no truncation; optionally it is folded into a running accumulator.
- Sits on the MAC datapath between the partial-product generator and the output register, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 12, operand width in bits (>=2)
OUT_WIDTH, WIDTH+2, result and accumulator width; must be >= WIDTH+2 so a plain three-operand sum never overflows

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream transaction valid
in_ready  output  1  block can accept a transaction this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
c  input  WIDTH  operand C, unsigned
acc_en  input  1  transaction adds into the accumulator
acc_clr  input  1  transaction clears the accumulator before use
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  OUT_WIDTH  result
ovf  output  1  sticky accumulator overflow (or saturation) flag

Behaviour:
- Reset: synchronous, active-low on clk.
  - While rst_n=0 at a rising edge: all pipeline valids, the accumulator, sum and ovf load 0.
  - in_ready is forced to 0 while rst_n=0.
  - Reset mid-operation drops in-flight transactions silently.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_valid, sum and ovf are held stable until the output transfer occurs.
- Stage 1 (carry-save):
  - On input transfer, register the bitwise sum s = a^b^c and the carry k = maj(a,b,c).
  - acc_en and acc_clr are registered alongside.
- Stage 2 (carry-propagate):
  - Compute r = s + (k<<1), zero-extended to OUT_WIDTH.
  - Stage 2 loads when stage 1 is valid and (!out_valid || out_ready).
- Flow control:
  - in_ready = !s1_valid || stage-2 load condition (combinational; single-entry skid per stage).
  - Capacity is 2 transactions.
  - Latency: 2 cycles from input transfer to out_valid with no backpressure.
  - Throughput: 1 transaction per cycle.
- Result on stage-2 load:
  - acc_en=0, acc_clr=0: sum = r; accumulator unchanged.
  - acc_en=0, acc_clr=1: sum = r; accumulator := 0; ovf := 0.
  - acc_en=1, acc_clr=0: t = acc + r (OUT_WIDTH+1 bits). acc := t mod 2^OUT_WIDTH and sum := acc. If t[OUT_WIDTH]=1, ovf := 1 (sticky).
  - acc_en=1, acc_clr=1: acc := r; sum := r; ovf := 0.
- The accumulator updates only on stage-2 load, never on stall cycles.
- Simultaneous input and output transfer in the same cycle with a full pipeline is legal; no bubble is inserted.

Optional Feature:
- Macro: CSA3_SAT_EN.
- Defined: when an accumulate overflows (t[OUT_WIDTH]=1), acc and sum become all-ones (2^OUT_WIDTH-1) and ovf := 1. Subsequent accumulates hold at all-ones until a clear.
- Undefined: modular wrap as described in Behaviour.
- Plain (acc_en=0) results are identical in both builds.

Test Plan (WIDTH=12, OUT_WIDTH=14):
- Plain sum: a=b=c=4095, acc_en=0 -> sum=12285 (0x2FFD) exactly 2 cycles after transfer, ovf=0.
- Accumulate: {1,2,3} with acc_en=1, acc_clr=1, then {10,20,30} with acc_en=1 -> sums 6, then 66; ovf=0.
- Overflow: two accumulates of 4095×3 (first with acc_clr=1) -> second sum=8186 with ovf=1 (wrap build), or sum=16383 with ovf=1 under CSA3_SAT_EN. A following acc_clr=1, acc_en=0 transaction of {0,0,1} -> sum=1, ovf=0.
- Backpressure: out_ready=0, send 3 back-to-back transactions -> in_ready drops after the 2nd transfer. Raise out_ready -> results emerge in order with no loss or duplication, one per cycle.
- Reset mid-flight: 2 transactions in the pipeline, pulse rst_n=0 for 1 cycle -> out_valid=0, sum=0, ovf=0, accumulator=0. The next accumulate of {1,1,1} yields 3.
